// File: rtl/tlc_pkg.sv
// Shared encodings for the multi-way traffic controller.
// Light and phase codes plus elaboration-time parameter checks.
`ifndef TLC_PKG_SV
`define TLC_PKG_SV

// Elaboration-time legality check; expands to a named generate block.
`define TLC_PARAM_CHECK(lbl, cond, msg) \
  if (!(cond)) begin : lbl \
    $error(msg); \
  end

package tlc_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  localparam logic [1:0] GREEN_PH  = 2'd0;
  localparam logic [1:0] YELLOW_PH = 2'd1;
  localparam logic [1:0] ALLRED_PH = 2'd2;

endpackage

`endif

// File: rtl/tlc_rr_select.sv
// Round-robin finder: first pending way after active_way, wrapping.
// Ports: pending/active_way in; valid/next_way out (falls back to way 0).
module tlc_rr_select #(
  parameter int NUM_WAYS = 4
) (
  input  logic [NUM_WAYS-1:0]         pending,
  input  logic [$clog2(NUM_WAYS)-1:0] active_way,
  output logic                        valid,
  output logic [$clog2(NUM_WAYS)-1:0] next_way
);

  localparam int AW = $clog2(NUM_WAYS);

  int w_best;
  int w_dist;

  // Pick the pending way with the smallest forward distance
  // from active_way; active_way itself is never pending.
  always_comb begin
    w_best   = NUM_WAYS;
    w_dist   = 0;
    next_way = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (pending[i]) begin
        if (i > int'(active_way))
          w_dist = i - int'(active_way);
        else
          w_dist = i + NUM_WAYS - int'(active_way);
        if (w_dist < w_best) begin
          w_best   = w_dist;
          next_way = AW'(i);
        end
      end
    end
    valid = (w_best < NUM_WAYS) || (active_way != '0);
  end

endmodule

// File: rtl/multi_way_traffic_controller.sv
// N-approach round-robin intersection controller with min/max green.
// Ports: clock, reset, req[N] in; light[2N], active_way, phase, green_start out.
module multi_way_traffic_controller
  import tlc_pkg::*;
#(
  parameter int NUM_WAYS    = 4,
  parameter int CNT_W       = 8,
  parameter int GREEN_MIN   = 5,
  parameter int GREEN_MAX   = 20,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_WAYS-1:0]         req,
  output logic [2*NUM_WAYS-1:0]       light,
  output logic [$clog2(NUM_WAYS)-1:0] active_way,
  output logic [1:0]                  phase,
  output logic                        green_start
);

  localparam int AW = $clog2(NUM_WAYS);
  localparam int LIM = 1 << CNT_W;

  `TLC_PARAM_CHECK(g_chk_ways,
    (NUM_WAYS >= 2) && (NUM_WAYS <= 16), "NUM_WAYS must be 2..16")
  `TLC_PARAM_CHECK(g_chk_gmin,
    (GREEN_MIN >= 1) && (GREEN_MIN < LIM), "GREEN_MIN out of range")
  `TLC_PARAM_CHECK(g_chk_gmax,
    (GREEN_MAX >= GREEN_MIN) && (GREEN_MAX < LIM), "GREEN_MAX out of range")
  `TLC_PARAM_CHECK(g_chk_yel,
    (YELLOW_TIME >= 1) && (YELLOW_TIME < LIM), "YELLOW_TIME out of range")
  `TLC_PARAM_CHECK(g_chk_red,
    (ALLRED_TIME >= 1) && (ALLRED_TIME < LIM), "ALLRED_TIME out of range")

  localparam logic [CNT_W-1:0] L_GMIN = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] L_GMAX = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] L_YEL  = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] L_RED  = CNT_W'(ALLRED_TIME - 1);

  logic [1:0]          r_phase;
  logic [AW-1:0]       r_active;
  logic [AW-1:0]       r_target;
  logic [CNT_W-1:0]    r_timer;
  logic                r_gs;

  logic [NUM_WAYS-1:0] w_pending;
  logic                w_valid;
  logic [AW-1:0]       w_next;
  logic                w_green_exit;
  logic                w_yel_done;
  logic                w_red_done;
  logic [CNT_W-1:0]    w_timer_inc;

  assign w_pending = req & ~(NUM_WAYS'(1) << r_active);

  tlc_rr_select #(
    .NUM_WAYS(NUM_WAYS)
  ) u_rr (
    .pending   (w_pending),
    .active_way(r_active),
    .valid     (w_valid),
    .next_way  (w_next)
  );

  // A dropped request only ends green once another way is selectable;
  // an idle way 0 therefore holds green forever.
  assign w_green_exit = (r_phase == GREEN_PH) &&
                        (r_timer >= L_GMIN) && w_valid &&
                        (!req[r_active] || (r_timer >= L_GMAX));
  assign w_yel_done = (r_phase == YELLOW_PH) && (r_timer == L_YEL);
  assign w_red_done = (r_phase == ALLRED_PH) && (r_timer == L_RED);

  assign w_timer_inc = (&r_timer) ? r_timer : r_timer + CNT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase  <= GREEN_PH;
      r_active <= '0;
      r_target <= '0;
      r_timer  <= '0;
      r_gs     <= 1'b0;
    end else begin
      r_gs <= w_red_done;
      unique case (1'b1)
        w_green_exit: begin
          r_target <= w_next;
          r_phase  <= YELLOW_PH;
          r_timer  <= '0;
        end
        w_yel_done: begin
          r_phase <= ALLRED_PH;
          r_timer <= '0;
        end
        w_red_done: begin
          r_phase  <= GREEN_PH;
          r_active <= r_target;
          r_timer  <= '0;
        end
        default: r_timer <= w_timer_inc;
      endcase
    end
  end

  always_comb begin
    light = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (AW'(i) == r_active) begin
        if (r_phase == GREEN_PH)
          light[2*i +: 2] = GREEN;
        else if (r_phase == YELLOW_PH)
          light[2*i +: 2] = YELLOW;
        else
          light[2*i +: 2] = RED;
      end
    end
  end

  assign active_way  = r_active;
  assign phase       = r_phase;
  assign green_start = r_gs;

endmodule
